// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrate, register operands, return result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default build is round-robin.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [5:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [5:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [5:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_y
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_next;
   logic   any_valid;
   logic   grant;
   logic   grant_id;

   assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign grant_id = ~req0_valid;
`else
   logic last;

   // Under contention the grant goes to whoever did not win most recently.
   assign grant_id = req1_valid & (~req0_valid | ~last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last <= 1'b1;
      end else if (grant) begin
         last <= grant_id;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      case (state)
         IDLE: begin
            if (any_valid) begin
               grant      = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Readies are forced low while reset is held, even though state is already IDLE.
   assign req0_ready = reset_n & grant & ~grant_id;
   assign req1_ready = reset_n & grant & grant_id;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_op <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
         rsp_id <= 1'b0;
      end else if (grant) begin
         alu_op <= grant_id ? req1_op : req0_op;
         alu_a  <= grant_id ? req1_a  : req0_a;
         alu_b  <= grant_id ? req1_b  : req0_b;
         rsp_id <= grant_id;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
      end else begin
         if (state == EXEC) begin
            rsp_y     <= alu_y;
            rsp_valid <= 1'b1;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a transaction-level reference model and a behavioural ALU.
module tb_alu_arbiter;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [5:0]       req0_op, req1_op;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [5:0]       alu_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_y;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [WIDTH-1:0] rsp_y;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y)
   );

   function automatic logic [WIDTH-1:0] alu_ref(input logic [5:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op[5:3])
         3'd0: r = a;
         3'd1: r = a + b;
         3'd2: r = a - b;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a + 1;
         3'd6: r = a - 1;
         default: r = b;
      endcase
      case (op[1:0])
         2'd0: return r;
         2'd1: return r << 1;
         2'd2: return r >> 1;
         default: return '0;
      endcase
   endfunction

   // The shared ALU sitting outside the arbiter.
   assign alu_y = alu_ref(alu_op, alu_a, alu_b);

   int vectors     = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: phase 0 = free, 1 = computing, 2 = response pending.
   int               phase;
   bit               m_last;
   bit               m_id;
   logic [5:0]       m_op;
   logic [WIDTH-1:0] m_a, m_b, m_y;
   bit               refill;
   bit               saw_rsp, seen_id, seen_r0, seen_r1;
   logic [WIDTH-1:0] seen_y;
   int               grants_dut[$];

   task automatic step();
      bit exp_r0, exp_r1, win;
      int granted;
      @(negedge clk);
      saw_rsp = rsp_valid;
      seen_y  = rsp_y;
      seen_id = rsp_id;
      seen_r0 = req0_ready;
      seen_r1 = req1_ready;
      exp_r0  = 1'b0;
      exp_r1  = 1'b0;
      win     = 1'b0;
      granted = -1;
      if (phase == 0 && (req0_valid || req1_valid)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         win = !req0_valid;
`else
         win = (req0_valid && req1_valid) ? !m_last : !req0_valid;
`endif
         exp_r0 = !win;
         exp_r1 = win;
      end
      check_val("req0_ready", req0_ready, exp_r0);
      check_val("req1_ready", req1_ready, exp_r1);
      check_val("rsp_valid", rsp_valid, phase == 2);
      if (phase == 2) begin
         check_val("rsp_id", rsp_id, m_id);
         check_val("rsp_y", rsp_y, m_y);
      end
      if (phase == 1) begin
         check_val("alu_op", alu_op, m_op);
         check_val("alu_a", alu_a, m_a);
         check_val("alu_b", alu_b, m_b);
      end
      if (req0_ready) grants_dut.push_back(0);
      else if (req1_ready) grants_dut.push_back(1);
      case (phase)
         0: if (req0_valid || req1_valid) begin
               m_id   = win;
               m_op   = win ? req1_op : req0_op;
               m_a    = win ? req1_a : req0_a;
               m_b    = win ? req1_b : req0_b;
               m_y    = alu_ref(m_op, m_a, m_b);
               m_last = win;
               phase  = 1;
               granted = win;
            end
         1: phase = 2;
         default: if (rsp_ready) phase = 0;
      endcase
      @(posedge clk);
      #1;
      if (!refill) begin
         if (granted == 0) req0_valid = 1'b0;
         if (granted == 1) req1_valid = 1'b0;
      end
   endtask

   task automatic set_req(input bit id, input logic [5:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
   endtask

   task automatic run_one(input string tag, input bit id, input logic [5:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_y);
      bit done = 1'b0;
      set_req(id, op, a, b);
      rsp_ready = 1'b1;
      for (int unsigned i = 0; i < 8 && !done; i++) begin
         step();
         if (saw_rsp) done = 1'b1;
      end
      check_val({tag, "_seen"}, done, 1'b1);
      check_val({tag, "_id"}, seen_id, id);
      check_val({tag, "_y"}, seen_y, exp_y);
   endtask

   task automatic drain();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      for (int unsigned i = 0; i < 6; i++) step();
   endtask

   initial begin
      bit done;
      reset_n = 1'b0;
      refill = 1'b0;
      phase = 0; m_last = 1'b1; m_id = 1'b0;
      m_op = '0; m_a = '0; m_b = '0; m_y = '0;
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 6'b001000; req0_a = 32'd5; req0_b = 32'd3;
      req1_valid = 1'b1; req1_op = '0; req1_a = '0; req1_b = '0;
      #3;
      check_val("rst_req0_ready", req0_ready, 1'b0);
      check_val("rst_req1_ready", req1_ready, 1'b0);
      check_val("rst_rsp_valid", rsp_valid, 1'b0);
      check_val("rst_rsp_id", rsp_id, 1'b0);
      check_val("rst_rsp_y", rsp_y, '0);
      check_val("rst_alu_op", alu_op, '0);
      check_val("rst_alu_a", alu_a, '0);
      check_val("rst_alu_b", alu_b, '0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Directed ALU cases.
      run_one("add", 1'b0, 6'b001000, 32'd5, 32'd3, 32'd8);
      run_one("sub_wrap", 1'b1, 6'b010000, 32'd0, 32'd1, 32'hFFFF_FFFF);
      run_one("add_shl", 1'b0, 6'b001001, 32'd5, 32'd3, 32'd16);
      run_one("and_shr", 1'b1, 6'b011010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h7800_7800);
      run_one("b_zero", 1'b0, 6'b111011, 32'h0, 32'h1234_5678, 32'h0);

      // Stall with both pending, then release.
      rsp_ready = 1'b0;
      set_req(1'b0, 6'b101000, 32'd41, 32'd0);
      set_req(1'b1, 6'b110000, 32'd10, 32'd0);
      done = 1'b0;
      for (int unsigned i = 0; i < 8 && !done; i++) begin
         step();
         if (saw_rsp) done = 1'b1;
      end
      check_val("stall_rsp_seen", done, 1'b1);
      for (int unsigned i = 0; i < 10; i++) step();
      rsp_ready = 1'b1;
      step();
      step();
      check_val("grant_after_stall", seen_r0 | seen_r1, 1'b1);
      drain();

      // Reset asserted during EXEC.
      set_req(1'b0, 6'b001000, 32'd7, 32'd9);
      step();
      check_val("mid_rst_in_exec", phase, 1);
      req1_valid = 1'b1;
      reset_n = 1'b0;
      #1;
      check_val("mid_rst_ready1", req1_ready, 1'b0);
      check_val("mid_rst_rsp_valid", rsp_valid, 1'b0);
      check_val("mid_rst_alu_a", alu_a, '0);
      check_val("mid_rst_alu_b", alu_b, '0);
      check_val("mid_rst_rsp_y", rsp_y, '0);
      phase = 0;
      m_last = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      reset_n = 1'b1;
      for (int unsigned i = 0; i < 5; i++) step();

      // Continuous contention; last pointer is fresh from reset.
      refill = 1'b1;
      rsp_ready = 1'b1;
      set_req(1'b0, 6'b000000, 32'hA, 32'h0);
      set_req(1'b1, 6'b111000, 32'h0, 32'hB);
      grants_dut.delete();
      for (int unsigned i = 0; i < 12; i++) step();
      refill = 1'b0;
      drain();
      check_val("rr_grant_count", grants_dut.size() >= 4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         int exp_g;
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = i % 2;
`endif
         check_val("rr_order", (i < grants_dut.size()) ? grants_dut[i] : -1, exp_g);
      end

      // Random traffic.
      for (int unsigned i = 0; i < 400; i++) begin
         if (!req0_valid && ($urandom % 3 == 0))
            set_req(1'b0, 6'($urandom), ($urandom % 2) ? $urandom : $urandom % 4, $urandom);
         if (!req1_valid && ($urandom % 3 == 0))
            set_req(1'b1, 6'($urandom), $urandom, ($urandom % 2) ? $urandom : '1);
         rsp_ready = ($urandom % 4) != 0;
         step();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
